vedic_mul_pipe: RTL
===================

Name: vedic_mul_pipe

Overview:
- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier; successor to the fixed 4x4 combinational multiplier.
- Recursively splits WIDTH-bit operands into quadrants down to 2x2 leaf products, then recombines one level per pipeline stage.
- Supports per-transaction signed/unsigned mode and valid/ready flow control on both sides.
- Sits between operand sources (DSP datapath, MAC wrappers) and accumulators.

Parameters:
- WIDTH, 8, operand width; power of two, 4..64.
- LATENCY, derived localparam = $clog2(WIDTH)+1, cycles from input accept to output valid; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_p  out  2*WIDTH  product; two's-complement when the beat's in_signed = 1.

Behaviour:
- Reset: every stage valid bit = 0; out_valid = 0; out_p = 0. in_ready is 1 once rst_n is high. Asserting reset mid-operation discards all in-flight beats with no partial output.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. All stages shift together when adv = 1 and hold when adv = 0. Bubbles are not collapsed.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - out_p is stable while out_valid && !out_ready.
  - in_* are ignored when in_ready = 0.
- Pipeline stages (each has a valid bit plus a sign bit):
  - S0: registers |a| and |b| as WIDTH-bit unsigned magnitudes, and neg = in_signed & (a[MSB] ^ b[MSB]). When in_signed = 0, magnitudes are the raw operands.
  - S1: registers all (WIDTH/2)^2 2x2 leaf products, 4 bits each.
  - S2..S(L): L = $clog2(WIDTH). Each stage combines groups of four n-bit-operand products into one 2n-bit-operand product: P = q0 + (q1<<n) + (q2<<n) + (q3<<2n), where q0 = lo*lo, q1 = hi_a*lo_b, q2 = lo_a*hi_b, q3 = hi*hi. The last stage conditionally negates: out_p = neg ? -P : P (mod 2^(2*WIDTH)).
  - For WIDTH=4 this gives S0, S1, S2, latency 3.
- Throughput: one beat per cycle with out_ready held high; latency exactly LATENCY cycles from accept to out_valid.
- Arithmetic edge cases:
  - The most-negative operand -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - The product of two most-negative operands is +2^(2*WIDTH-2), which fits.
  - Zero with neg = 1 yields 0.
- Simultaneous events:
  - Accept and consume in the same cycle are legal; there is no loss or duplication.
  - in_valid may drop at any time; it creates a bubble only.

Optional Feature:
- Macro: VEDIC_MUL_PIPE_TAG_EN.
- Defined:
  - Adds parameter TAG_W (default 4), input in_tag[TAG_W-1:0] and output out_tag[TAG_W-1:0].
  - The tag travels with its beat through every stage, so out_tag equals the accepted in_tag aligned with out_p.
  - out_tag resets to 0 and is held during stall.
- Undefined: no tag ports and no tag registers; behaviour otherwise identical.

Decomposition:
- Package vedic_pkg:
  - function vedic_latency(width) returning $clog2(width)+1;
  - constants VEDIC_MIN_W = 4 and VEDIC_MAX_W = 64;
  - typedef vedic_mode_e {VEDIC_UNSIGNED, VEDIC_SIGNED}.
- Elaboration check: assert WIDTH is a power of two within [VEDIC_MIN_W, VEDIC_MAX_W].
- Sub-module vedic_quad_combine, parameter N: purely combinational four-product recombination. It is instantiated in generate loops per level; the registers stay in vedic_mul_pipe.

Test Plan:
- WIDTH=8, unsigned: a=0xFF, b=0xFF, out_ready=1 -> out_p=0xFE01 exactly 4 cycles after accept.
- WIDTH=8, signed: (-128)*(-128) -> 0x4000; (-1)*127 -> 0xFF81; 0*(-5) -> 0x0000. Issue back-to-back -> three consecutive out_valid cycles, in order.
- Backpressure, WIDTH=8: stream 10 random beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, out_p stable, and all 10 products correct with none dropped or duplicated.
- Reset mid-flight: 3 beats in pipeline, pulse rst_n low asynchronously -> out_valid=0 and out_p=0 immediately. After release, no stale beat appears; the next beat 7*9 gives 63 after 4 cycles.
- WIDTH=4 and WIDTH=16 sweeps: exhaustive 4-bit signed and unsigned, plus 10k random 16-bit -> match the reference model, with latency 3 and 5 respectively.
- With VEDIC_MUL_PIPE_TAG_EN: tags 0..9 on consecutive beats under random out_ready -> out_tag sequence 0..9, each aligned with its product.

Source files
------------

// File: rtl/vedic_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the pipelined Vedic (Urdhva-Tiryagbhyam) multiplier:
// supported operand-width range, the per-beat arithmetic mode and the
// latency helper used by vedic_mul_pipe.
// ---------------------------------------------------------------------------
package vedic_pkg;

  localparam int VEDIC_MIN_W = 4;
  localparam int VEDIC_MAX_W = 64;

  // Per-beat operand interpretation, driven from the in_signed port
  typedef enum logic {
    VEDIC_UNSIGNED = 1'b0,
    VEDIC_SIGNED   = 1'b1
  } vedic_mode_e;

  // One magnitude stage, one leaf stage, then one stage per recombination
  // level; the last recombination level also applies the sign
  function automatic int vedic_latency(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/vedic_quad_combine.sv
// ---------------------------------------------------------------------------
// vedic_quad_combine
// Purely combinational recombination of four partial products of N-bit
// operand halves into one product of 2N-bit operands:
//   p = q0 + (q1 << N) + (q2 << N) + (q3 << 2N)
// Ports:
//   q0_i  [2N-1:0]  lo_a * lo_b
//   q1_i  [2N-1:0]  hi_a * lo_b
//   q2_i  [2N-1:0]  lo_a * hi_b
//   q3_i  [2N-1:0]  hi_a * hi_b
//   p_o   [4N-1:0]  combined product
// ---------------------------------------------------------------------------
module vedic_quad_combine
  import vedic_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2*N-1:0] q0_i,
  input  logic [2*N-1:0] q1_i,
  input  logic [2*N-1:0] q2_i,
  input  logic [2*N-1:0] q3_i,
  output logic [4*N-1:0] p_o
);

  // The shifts are written as zero-padded concatenations so every term is
  // already 4N bits wide; the sum of four full quadrant products always fits
  always_comb begin
    p_o = {{(2*N){1'b0}}, q0_i}
        + {{N{1'b0}}, q1_i, {N{1'b0}}}
        + {{N{1'b0}}, q2_i, {N{1'b0}}}
        + {q3_i, {(2*N){1'b0}}};
  end

endmodule

// File: rtl/vedic_mul_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mul_pipe
// Parametrised, pipelined Vedic multiplier. Operands are converted to
// magnitudes (S0), split into all 2x2 leaf products (S1) and recombined one
// quadrant level per stage (S2..S(L), L = log2(WIDTH)); the last level
// applies the sign. Latency is LATENCY = log2(WIDTH)+1 cycles. A single
// global advance moves every stage together; bubbles are not collapsed.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat can be accepted this cycle
//   in_a       in   [WIDTH-1:0] multiplicand
//   in_b       in   [WIDTH-1:0] multiplier
//   in_signed  in   1 = two's-complement operands, 0 = unsigned
//   out_valid  out  product valid
//   out_ready  in   downstream accepts the product
//   out_p      out  [2*WIDTH-1:0] product
//   in_tag     in   [TAG_W-1:0] beat tag   (VEDIC_MUL_PIPE_TAG_EN only)
//   out_tag    out  [TAG_W-1:0] beat tag   (VEDIC_MUL_PIPE_TAG_EN only)
//
// Optional feature macro: VEDIC_MUL_PIPE_TAG_EN adds a TAG_W-bit tag that
// travels with each beat and emerges aligned with its product.
// ---------------------------------------------------------------------------
module vedic_mul_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef VEDIC_MUL_PIPE_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
`ifdef VEDIC_MUL_PIPE_TAG_EN
  ,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]     out_tag
`endif
);

  localparam int LATENCY = vedic_latency(WIDTH);
  localparam int LVLS    = $clog2(WIDTH);
  // All product levels live in one flat vector: level k holds
  // (WIDTH/2^k)^2 products of 2^(k+1) bits, i.e. 2*WIDTH^2/2^k bits, so the
  // levels together occupy 2*WIDTH^2 - 2*WIDTH bits and the final product
  // sits in the top 2*WIDTH bits.
  localparam int PW_TOT  = 2*WIDTH*WIDTH - 2*WIDTH;

  if (((WIDTH & (WIDTH - 1)) != 0) || (WIDTH < VEDIC_MIN_W) || (WIDTH > VEDIC_MAX_W)) begin : g_bad_width
    $error("vedic_mul_pipe: WIDTH=%0d must be a power of two in [%0d,%0d]",
           WIDTH, VEDIC_MIN_W, VEDIC_MAX_W);
  end
  if (LATENCY != LVLS + 1) begin : g_bad_latency
    $error("vedic_mul_pipe: latency helper disagrees with stage count");
  end

  logic              adv;
  vedic_mode_e       mode;
  logic [WIDTH-1:0]  magA_d, magB_d, magA_q, magB_q;
  logic              neg_d;
  logic [LVLS:0]     valid_q;
  logic [LVLS-1:0]   neg_q;
  logic [PW_TOT-1:0] prod_d, prod_q;

  // Whole pipeline moves when the output slot is empty or being drained
  assign adv       = !valid_q[LVLS] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[LVLS];
  assign out_p     = prod_q[PW_TOT-1 -: 2*WIDTH];

  // Magnitude conversion; -2^(WIDTH-1) negates to itself, which read as
  // unsigned is exactly its magnitude, so no extra bit is needed
  always_comb begin
    mode   = vedic_mode_e'(in_signed);
    magA_d = in_a;
    magB_d = in_b;
    neg_d  = 1'b0;
    if (mode == VEDIC_SIGNED) begin
      if (in_a[WIDTH-1]) magA_d = -in_a;
      if (in_b[WIDTH-1]) magB_d = -in_b;
      neg_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end
  end

  // Operand stage plus the valid/sign shift chains that shadow the product
  // levels: index 0 belongs to S0, index k to recombination level k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      neg_q   <= '0;
      magA_q  <= '0;
      magB_q  <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[LVLS-1:0], in_valid};
      neg_q   <= {neg_q[LVLS-2:0], neg_d};
      magA_q  <= magA_d;
      magB_q  <= magB_d;
    end
  end

  // Level k works on operand chunks of N = 2^k bits; element (i,j) is the
  // product of a-chunk i and b-chunk j, stored at index i*M + j
  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int N   = 1 << k;
    localparam int M   = WIDTH / N;
    localparam int PW  = 2 * N;
    localparam int OFF = 2*WIDTH*WIDTH - ((4*WIDTH*WIDTH) >> k);

    if (k == 1) begin : g_leaf
      for (genvar i = 0; i < M; i++) begin : g_i
        for (genvar j = 0; j < M; j++) begin : g_j
          assign prod_d[OFF + (i*M + j)*PW +: PW] =
            {2'b00, magA_q[2*i +: 2]} * {2'b00, magB_q[2*j +: 2]};
        end
      end
    end else begin : g_comb
      localparam int PM   = 2 * M;
      localparam int PPW  = N;
      localparam int POFF = 2*WIDTH*WIDTH - ((4*WIDTH*WIDTH) >> (k - 1));
      for (genvar i = 0; i < M; i++) begin : g_i
        for (genvar j = 0; j < M; j++) begin : g_j
          logic [PW-1:0] sum;
          vedic_quad_combine #(.N(N/2)) u_comb (
            .q0_i(prod_q[POFF + ((2*i)  *PM + 2*j)  *PPW +: PPW]),
            .q1_i(prod_q[POFF + ((2*i+1)*PM + 2*j)  *PPW +: PPW]),
            .q2_i(prod_q[POFF + ((2*i)  *PM + 2*j+1)*PPW +: PPW]),
            .q3_i(prod_q[POFF + ((2*i+1)*PM + 2*j+1)*PPW +: PPW]),
            .p_o (sum)
          );
          // Only the final level (a single product) carries the sign
          if (k == LVLS) begin : g_sign
            assign prod_d[OFF +: PW] = neg_q[LVLS-1] ? -sum : sum;
          end else begin : g_plain
            assign prod_d[OFF + (i*M + j)*PW +: PW] = sum;
          end
        end
      end
    end
  end

  // All product levels register together; holding on stall keeps out_p stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (adv) begin
      prod_q <= prod_d;
    end
  end

`ifdef VEDIC_MUL_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_q [LVLS+1];

  // Tag rides alongside its beat through the same number of stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LVLS; s++) tag_q[s] <= '0;
    end else if (adv) begin
      tag_q[0] <= in_tag;
      for (int s = 1; s <= LVLS; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign out_tag = tag_q[LVLS];
`endif

endmodule
